// File: rtl/qpu_ram_arbiter.sv
// qpu_ram_arbiter: shares the QPU working-RAM port between the QPU core and a
// host/debug port. The core has priority. The host is served in an idle core
// cycle, or after MAX_WAIT starved cycles by stalling the core for one slot.
// Each host access takes one HOST slot (RAM driven with the latched host
// fields) followed by one CAPT slot (read data returned by the sync-read RAM
// is captured). host_ack is registered, so it pulses in the cycle after CAPT.
`timescale 1ns/1ps

module qpu_ram_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  // core side
  input  logic          core_req,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  input  logic          core_we,
  output logic          core_rdy,
  // host / debug side
  input  logic          host_req,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  input  logic          host_we,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  // RAM macro side
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  input  logic [DW-1:0] ram_rdata
);

  localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOST = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t         state_reg, state_next;
  logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;
  logic [AW-1:0]  host_addr_reg;
  logic [DW-1:0]  host_wdata_reg;
  logic           host_we_reg;
  logic           host_ack_reg;
  logic [DW-1:0]  host_rdata_reg;
  logic           grant;

  // Host wins in IDLE when the core is quiet or the host has starved long enough.
  assign grant = host_req & (~core_req | (wait_cnt_reg == WAIT_MAX));

  // State and starvation counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // Next-state logic; the counter only advances while host and core collide.
  always_comb begin
    state_next    = IDLE;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (grant) begin
          state_next = HOST;
        end else if (host_req && core_req && (wait_cnt_reg != WAIT_MAX)) begin
          wait_cnt_next = wait_cnt_reg + WCW'(1);
        end
      end
      HOST: begin
        state_next    = CAPT;
        wait_cnt_next = '0;
      end
      CAPT: begin
        state_next = IDLE;
      end
      default: begin
        state_next    = IDLE;
        wait_cnt_next = '0;
      end
    endcase
  end

  // RAM port mux: core fields pass straight through except during the HOST slot.
  always_comb begin
    ram_addr  = core_addr;
    ram_wdata = core_wdata;
    ram_we    = core_req & core_we;
    core_rdy  = 1'b1;
    if (state_reg == HOST) begin
      ram_addr  = host_addr_reg;
      ram_wdata = host_wdata_reg;
      ram_we    = host_we_reg;
      core_rdy  = 1'b0;
    end
    // Reset blocks RAM writes and never stalls the core.
    if (reset) begin
      ram_we   = 1'b0;
      core_rdy = 1'b1;
    end
  end

  // Latch the host request at grant so the HOST slot is independent of host timing.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_addr_reg  <= '0;
      host_wdata_reg <= '0;
      host_we_reg    <= 1'b0;
    end else if ((state_reg == IDLE) && grant) begin
      host_addr_reg  <= host_addr;
      host_wdata_reg <= host_wdata;
      host_we_reg    <= host_we;
    end
  end

  // Capture read data in CAPT and raise a one-cycle acknowledge after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      host_ack_reg   <= 1'b0;
      host_rdata_reg <= '0;
    end else begin
      host_ack_reg <= (state_reg == CAPT);
      if ((state_reg == CAPT) && !host_we_reg) begin
        host_rdata_reg <= ram_rdata;
      end
    end
  end

  assign host_ack   = host_ack_reg;
  assign host_rdata = host_rdata_reg;

endmodule
